// File: rtl/dmem_pkg.sv
// Shared constants, FSM state type and address helper for the line data memory.
package dmem_pkg;

  localparam int unsigned LINE_W   = 256;
  localparam int unsigned OFFSET_W = 5;
  localparam int unsigned ADDR_W   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } dmem_state_e;

  // Line number of a byte address; the caller truncates to its array depth (aliasing).
  function automatic logic [ADDR_W-1:0] line_index(input logic [ADDR_W-1:0] addr);
    return addr >> OFFSET_W;
  endfunction

endpackage

// File: rtl/line_data_memory_if.sv
// Line-memory request/response bundle between the data cache (master) and memory (slave).
interface line_data_memory_if;
  import dmem_pkg::*;

  logic              enable_i;
  logic              write_i;
  logic [ADDR_W-1:0] addr_i;
  logic [LINE_W-1:0] data_i;
  logic              ack_o;
  logic [LINE_W-1:0] data_o;
  logic              err_o;

  modport master (
    output enable_i, write_i, addr_i, data_i,
    input  ack_o, data_o, err_o
  );

  modport slave (
    input  enable_i, write_i, addr_i, data_i,
    output ack_o, data_o, err_o
  );

endinterface

// File: rtl/dmem_line_array.sv
// Line storage with synchronous write and registered read; contents are not reset.
module dmem_line_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_W = 9
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               we_i,
  input  logic               re_i,
  input  logic [DEPTH_W-1:0] idx_i,
  input  logic [LINE_W-1:0]  wdata_i,
  output logic [LINE_W-1:0]  rdata_o
);

  localparam int unsigned LINES = 2 ** DEPTH_W;

  logic [LINE_W-1:0] mem_q [LINES];
  logic [LINE_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
  end

  // Read register holds the last read line until the next read commits.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/line_data_memory.sv
// Fixed-latency line memory responder: one read/write in flight, single-cycle ack.
// Optional protocol checker enabled with `define DMEM_PROTOCOL_CHECK_EN.
module line_data_memory
  import dmem_pkg::*;
#(
  parameter int unsigned LATENCY = 10,
  parameter int unsigned DEPTH_W = 9
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  line_data_memory_if.slave    bus
);

  localparam int unsigned CNT_W = $clog2(LATENCY);

  dmem_state_e        state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               wr_q;
  logic [DEPTH_W-1:0] idx_q;
  logic [LINE_W-1:0]  wdata_q;
  logic               ack_q;

  logic [DEPTH_W-1:0] idx_c;
  logic               commit_c;

  assign idx_c    = DEPTH_W'(line_index(bus.addr_i));
  assign commit_c = (state_q == BUSY) && (cnt_q == '0);

  // Request latch, latency counter and ack pulse.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= commit_c;
      unique case (state_q)
        IDLE: begin
          if (bus.enable_i) begin
            wr_q    <= bus.write_i;
            idx_q   <= idx_c;
            wdata_q <= bus.data_i;
            cnt_q   <= CNT_W'(LATENCY - 2);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (commit_c) state_q <= ACK;
          else          cnt_q   <= cnt_q - CNT_W'(1);
        end
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  dmem_line_array #(
    .DEPTH_W (DEPTH_W)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (commit_c & wr_q),
    .re_i    (commit_c & ~wr_q),
    .idx_i   (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (bus.data_o)
  );

  assign bus.ack_o = ack_q;

`ifdef DMEM_PROTOCOL_CHECK_EN
  logic err_q;

  // Sticky flag: requester must hold the request stable until ack.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_q <= 1'b0;
    end else if ((state_q == BUSY) &&
                 (!bus.enable_i || (bus.write_i != wr_q) ||
                  (idx_c != idx_q) || (bus.data_i != wdata_q))) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif

endmodule

// File: tb/tb_line_data_memory.sv
// Self-checking bench for line_data_memory: directed table, reset/protocol sequences, random traffic.
module tb_line_data_memory;
  import dmem_pkg::*;

  localparam int unsigned LAT    = 10;
  localparam int unsigned DW     = 9;
  localparam int unsigned NLINES = 512;
  localparam int unsigned NRAND  = 40;
`ifdef DMEM_PROTOCOL_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  line_data_memory_if bus();

  line_data_memory #(
    .LATENCY (LAT),
    .DEPTH_W (DW)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [255:0] mem_m   [NLINES];
  bit           valid_m [NLINES];
  logic [255:0] last_rd;
  bit           b2b;

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
    logic [255:0] exp_do;
    bit           keep;
  } vec_t;

  vec_t vecs [9];

  localparam logic [255:0] A5   = {32{8'hA5}};
  localparam logic [255:0] PAT  = {4{64'h0123_4567_89AB_CDEF}};
  localparam logic [255:0] D40  = {8{32'hC0DE_0040}};
  localparam logic [255:0] D20  = {8{32'hBEEF_0020}};
  localparam logic [255:0] OLD7 = {8{32'h0000_0707}};
  localparam logic [255:0] NEW7 = {8{32'hFFFF_7777}};
  localparam logic [255:0] DX   = {8{32'hDADA_0008}};
  localparam logic [255:0] DY   = {8{32'h5555_AAAA}};
  localparam logic [255:0] DOLD = {8{32'h0BAD_0010}};

  function automatic int line_of(logic [31:0] a);
    return int'((a / 32) % NLINES);
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One request from the current negedge; ack expected after LAT edges (one more if issued during ACK).
  task automatic txn(input bit wr, input logic [31:0] a, input logic [255:0] d,
                     input logic [255:0] exp_do, input bit keep, input string nm);
    int exp_k;
    exp_k = b2b ? LAT + 1 : LAT;
    bus.enable_i = 1'b1;
    bus.write_i  = wr;
    bus.addr_i   = a;
    bus.data_i   = d;
    for (int k = 1; k <= exp_k; k++) begin
      @(negedge clk);
      chk({nm, "_ack"}, 256'(bus.ack_o), 256'(k == exp_k));
    end
    chk({nm, "_data"}, bus.data_o, exp_do);
    if (wr) begin
      mem_m[line_of(a)]   = d;
      valid_m[line_of(a)] = 1'b1;
    end else begin
      last_rd = exp_do;
    end
    b2b = keep;
    if (!keep) begin
      bus.enable_i = 1'b0;
      @(negedge clk);
      chk({nm, "_ack_low"}, 256'(bus.ack_o), 256'(0));
      chk({nm, "_data_hold"}, bus.data_o, exp_do);
    end
  endtask

  initial begin
    bit           wr;
    int           ln;
    logic [31:0]  a;
    logic [255:0] d;
    logic [255:0] e;
    bit           keep;

    vecs[0] = '{1'b1, 32'h0000_0060, A5,      256'h0, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0060, 256'h0,  A5,     1'b0};
    vecs[2] = '{1'b1, 32'h0000_007C, PAT,     A5,     1'b0};
    vecs[3] = '{1'b0, 32'h0000_0060, 256'h0,  PAT,    1'b0};
    vecs[4] = '{1'b1, 32'h0000_0800, D40,     PAT,    1'b0};
    vecs[5] = '{1'b1, 32'h0000_0400, D20,     PAT,    1'b1};
    vecs[6] = '{1'b0, 32'h0000_0800, 256'h0,  D40,    1'b0};
    vecs[7] = '{1'b1, 32'h0000_00E0, OLD7,    D40,    1'b0};
    vecs[8] = '{1'b0, 32'h0000_4400, 256'h0,  D20,    1'b0};

    for (int i = 0; i < int'(NLINES); i++) valid_m[i] = 1'b0;
    b2b          = 1'b0;
    last_rd      = '0;
    rst_n        = 1'b0;
    bus.enable_i = 1'b0;
    bus.write_i  = 1'b0;
    bus.addr_i   = '0;
    bus.data_i   = '0;

    repeat (3) @(negedge clk);
    chk("rst_ack", 256'(bus.ack_o), 256'(0));
    chk("rst_data", bus.data_o, 256'h0);
    chk("rst_err", 256'(bus.err_o), 256'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_ack", 256'(bus.ack_o), 256'(0));
    end
    chk("idle_data", bus.data_o, 256'h0);
    chk("idle_err", 256'(bus.err_o), 256'(0));

    for (int i = 0; i < 9; i++)
      txn(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp_do, vecs[i].keep,
          $sformatf("vec%0d", i));

    // Reset in cycle T+5 of a write to line 7; enable stays high across reset.
    bus.enable_i = 1'b1;
    bus.write_i  = 1'b1;
    bus.addr_i   = 32'h0000_00E0;
    bus.data_i   = NEW7;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("rw_ack", 256'(bus.ack_o), 256'(0));
    end
    rst_n = 1'b0;
    #1;
    chk("rw_rst_data", bus.data_o, 256'h0);
    chk("rw_rst_ack", 256'(bus.ack_o), 256'(0));
    repeat (2) @(negedge clk);
    chk("rw_rst_data2", bus.data_o, 256'h0);
    chk("rw_rst_ack2", 256'(bus.ack_o), 256'(0));
    chk("rw_rst_err", 256'(bus.err_o), 256'(0));
    bus.write_i = 1'b0;
    last_rd     = '0;
    rst_n       = 1'b1;
    txn(1'b0, 32'h0000_00E0, 256'h0, OLD7, 1'b0, "rw_line7");

    // Address/data change mid-BUSY: access goes to the originally latched line.
    txn(1'b1, 32'h0000_0140, DOLD, last_rd, 1'b0, "p_pre");
    bus.enable_i = 1'b1;
    bus.write_i  = 1'b1;
    bus.addr_i   = 32'h0000_0100;
    bus.data_i   = DX;
    for (int k = 1; k <= int'(LAT); k++) begin
      @(negedge clk);
      if (k == 3) begin
        bus.addr_i = 32'h0000_0140;
        bus.data_i = DY;
      end
      chk("p_ack", 256'(bus.ack_o), 256'(k == int'(LAT)));
    end
    chk("p_data", bus.data_o, last_rd);
    bus.enable_i = 1'b0;
    mem_m[8]     = DX;
    valid_m[8]   = 1'b1;
    @(negedge clk);
    chk("p_err", 256'(bus.err_o), 256'(ERR_EN));
    txn(1'b0, 32'h0000_0100, 256'h0, DX, 1'b0, "p_rd_orig");
    txn(1'b0, 32'h0000_0140, 256'h0, DOLD, 1'b0, "p_rd_other");
    chk("p_err_sticky", 256'(bus.err_o), 256'(ERR_EN));

    // Random traffic against the reference model, with aliasing upper bits and back-to-back pairs.
    for (int i = 0; i < int'(NRAND); i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = $urandom;
      a  = {a[31:14], 9'($urandom_range(0, 15)), a[4:0]};
      ln = line_of(a);
      if (!wr && !valid_m[ln]) wr = 1'b1;
      d    = wr ? rand_line() : 256'h0;
      e    = wr ? last_rd : mem_m[ln];
      keep = ($urandom_range(0, 3) == 0) && (i != int'(NRAND) - 1);
      txn(wr, a, d, e, keep, $sformatf("rnd%0d", i));
    end
    chk("final_err", 256'(bus.err_o), 256'(ERR_EN));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/line_data_memory.md
# line_data_memory

Responder side of the 256-bit line-memory interface used by the data cache controller. It accepts one line read or line write at a time and completes it after a fixed, parameterised latency. Completion is signalled with a single-cycle acknowledge. It sits below the data cache as the main-memory model for simulation and FPGA builds.

## Interface
- LATENCY, 10, cycles from request sample to ack_o; legal range ≥ 2
- DEPTH_W, 9, log2 of number of 32-byte lines stored (default 512 lines = 16 KiB)
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- enable_i  in  1  request valid; requester holds it high until ack_o
- write_i  in  1  1 = line write, 0 = line read; held with enable_i
- addr_i  in  32  byte address; bits [4:0] ignored, line index = addr_i[5+DEPTH_W-1:5], upper bits ignored (aliasing)
- data_i  in  256  write line, held with enable_i
- ack_o  out  1  one-cycle completion pulse
- data_o  out  256  read line, registered
- err_o  out  1  sticky protocol-violation flag (see Configuration)

## Operation
- FSM states: IDLE, BUSY, ACK.
- IDLE:
  - enable_i=1 at a clock edge → latch write_i, line index and data_i.
  - Load the down-counter with LATENCY-2 and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - counter ≠ 0 → decrement.
  - counter = 0 → perform the access at this edge and go to ACK:
    - write: array[index] ← latched data.
    - read: data_o ← array[index].
- ACK:
  - ack_o=1. Go to IDLE unconditionally. enable_i is not sampled in ACK.
- Access uses latched fields only. Input changes after the sample edge have no effect.
- If enable_i drops during BUSY, the access still commits and ack_o still pulses.
- Writes leave data_o unchanged.
- data_o holds the last read line until the next read commits.
- Back-to-back requests: if enable_i is still high in the IDLE cycle after ACK, it is sampled as a new request. This covers a writeback followed directly by a refill.
- Counter width is $clog2(LATENCY); no wrap is possible.
- Array contents are not initialised by reset. The bench preloads the array via hierarchical access or $readmemh.

## Timing
- Reset values: ack_o=0, data_o=0, err_o=0, state=IDLE, counter=0.
- Request first seen high in IDLE cycle T → ack_o high exactly in cycle T+LATENCY, low otherwise.
- data_o is valid from cycle T+LATENCY and stays stable at least through T+LATENCY+1. The requester writes its cache in the cycle after ack.
- Minimum spacing between acks is LATENCY+1 cycles, because of the one IDLE sample cycle.
- Reset asserted mid-operation:
  - Immediately return to IDLE; ack_o=0 and data_o=0.
  - A pending write is dropped; the array is unchanged.
  - After release, a still-high enable_i is treated as a new request.

## Configuration
- DMEM_PROTOCOL_CHECK_EN defined:
  - err_o sets and stays set until reset if, during BUSY, enable_i goes low, or write_i, the line index or data_i differ from the latched values.
  - The access itself is unaffected.
- DMEM_PROTOCOL_CHECK_EN undefined: the checker logic is absent and err_o is tied to 0.

## Structure
- Package dmem_pkg:
  - LINE_W=256, OFFSET_W=5.
  - State enum {IDLE, BUSY, ACK}.
  - Function to extract the line index from an address.
- Sub-module dmem_line_array:
  - 2^DEPTH_W × 256 storage.
  - Synchronous write enable and synchronous registered read, driven from the FSM commit strobe.

## Test plan
- Reset, then idle 20 cycles → ack_o never high, data_o=0, err_o=0.
- Preload line 3 = 256'hA5…A5. Read addr 0x60 with enable held → ack_o in cycle T+10 only. data_o=A5…A5 in T+10 and T+11.
- Write 256'h1234…(pattern) to addr 0x7C. Then read addr 0x60, which is the same line since offset is ignored → read returns the pattern. data_o unchanged during the write ack.
- Writeback-then-refill: write to 0x400 with enable still high in the cycle after ack, switched to a read of 0x800 → second ack at exactly 11 cycles after the first. Data from line 0x40.
- Assert rst_i in cycle T+5 of a write to line 7 → no ack. Line 7 retains its old value. Outputs are 0 during reset.
- With DMEM_PROTOCOL_CHECK_EN, change addr_i during BUSY → err_o=1 and stays 1. The access completes to the originally latched line. Without the macro, err_o stays 0.
